// File: rtl/memory_ctrl_pkg.sv
// Shared types for memory_ctrl: sequencer state encoding and byte-lane width.
package memory_ctrl_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/memory_ctrl_mem_read_pipe.sv
// Read-return delay line: DEPTH register stages carrying {valid, data}.
// Each stage's data only loads with valid, so the output holds its last value.
module mem_read_pipe #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DEPTH-1:0]      valid_q;
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/memory_ctrl.sv
// Single-port byte-writable RAM with req/ready handshake, clear sequencer
// over the low CLEAR_DEPTH words, and a 1- or 2-stage registered read path.
module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter     FILE_NAME    = "mem_init.mif",
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int CLEAR_DEPTH  = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    clr,
  output logic                    ready,
  output logic                    busy,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_W;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(CLEAR_DEPTH - 1);
  // FILE_NAME only feeds the synthesis init attribute below.
  localparam int UNUSED_FILE_NAME_BITS = $bits(FILE_NAME);

  (* ram_init_file = FILE_NAME *)
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q;
  logic                  busy_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  acc_wr;
  logic                  acc_rd;

  assign ready  = (state_q == ST_IDLE) && !clr;
  assign acc_wr = req && ready && we;
  assign acc_rd = req && ready && !we;
  assign busy   = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= (CLEAR_DEPTH == 0) ? ST_IDLE : ST_CLEAR;
      busy_q  <= (CLEAR_DEPTH != 0);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == CLR_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr && (CLEAR_DEPTH != 0)) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Array has no reset; the rst_n gate keeps reset from scrubbing mem[0].
  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_CLEAR)) begin
      mem[cnt_q] <= '0;
    end else if (acc_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

  mem_read_pipe #(
    .DEPTH      (READ_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_read_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (acc_rd),
    .data_i  (mem[addr]),
    .valid_o (rvalid),
    .data_o  (rdata)
  );

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed bench: drives one stimulus into two memory_ctrl instances,
// READ_LATENCY=1 (suffix 1) and READ_LATENCY=2 (suffix 2).
module tb_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, req, we, clr;
  logic [5:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        ready1, busy1, rvalid1, ready2, busy2, rvalid2;
  logic [15:0] rdata1, rdata2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .CLEAR_DEPTH(8), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .clr(clr), .ready(ready1), .busy(busy1), .rvalid(rvalid1), .rdata(rdata1));

  memory_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .CLEAR_DEPTH(8), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .clr(clr), .ready(ready2), .busy(busy2), .rvalid(rvalid2), .rdata(rdata2));

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [5:0] a, input logic [15:0] d,
                     input logic [1:0] b, input logic [15:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_vec(input vec_t v);
    @(negedge clk);
    req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata; be = v.be;
    #1;
    chk($sformatf("ready1 a%0d", v.addr), ready1, 1);
    chk($sformatf("ready2 a%0d", v.addr), ready2, 1);
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    chk($sformatf("rvalid1 lat1 a%0d", v.addr), rvalid1, !v.we);
    chk($sformatf("rvalid2 lat1 a%0d", v.addr), rvalid2, 0);
    if (!v.we) chk($sformatf("rdata1 a%0d", v.addr), rdata1, v.exp);
    @(negedge clk);
    chk($sformatf("rvalid1 lat2 a%0d", v.addr), rvalid1, 0);
    chk($sformatf("rvalid2 lat2 a%0d", v.addr), rvalid2, !v.we);
    if (!v.we) begin
      chk($sformatf("rdata2 a%0d", v.addr), rdata2, v.exp);
      chk($sformatf("rdata1 hold a%0d", v.addr), rdata1, v.exp);
    end
  endtask

  // Starts on a negedge where busy is expected high; counts busy samples.
  task automatic wait_clear(input string nm, input int expected, input int pulse_at);
    int n = 0;
    while (busy1 && n < 20) begin
      clr = (n == pulse_at);
      #1;
      chk($sformatf("%s ready1 low", nm), ready1, 0);
      chk($sformatf("%s busy2", nm), busy2, 1);
      n++;
      @(negedge clk);
    end
    clr = 1'b0;
    #1;
    chk($sformatf("%s busy cycles", nm), n, expected);
    chk($sformatf("%s ready1 after", nm), ready1, 1);
    chk($sformatf("%s ready2 after", nm), ready2, 1);
  endtask

  logic [15:0] d1[5], d2[5];
  logic        v1[5], v2[5];
  logic [15:0] expd[3];

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; wdata = '0; be = '0;
    expd = '{16'h0011, 16'h0022, 16'h0033};

    add(0, 6'd0, 16'h0, 2'b00, 16'h0000);
    add(0, 6'd3, 16'h0, 2'b00, 16'h0000);
    add(0, 6'd7, 16'h0, 2'b00, 16'h0000);
    add(1, 6'd8, 16'h5A5A, 2'b11, 16'h0);
    add(1, 6'd5, 16'hA5A5, 2'b11, 16'h0);
    add(1, 6'd5, 16'h3C00, 2'b10, 16'h0);
    add(0, 6'd5, 16'h0, 2'b00, 16'h3CA5);
    add(1, 6'd5, 16'hFFFF, 2'b00, 16'h0);
    add(0, 6'd5, 16'h0, 2'b00, 16'h3CA5);
    add(1, 6'd6, 16'h1234, 2'b01, 16'h0);
    add(0, 6'd6, 16'h0, 2'b00, 16'h0034);
    add(1, 6'd63, 16'hCAFE, 2'b11, 16'h0);
    add(0, 6'd63, 16'h0, 2'b00, 16'hCAFE);
    add(1, 6'd1, 16'h0011, 2'b11, 16'h0);
    add(1, 6'd2, 16'h0022, 2'b11, 16'h0);
    add(1, 6'd3, 16'h0033, 2'b11, 16'h0);

    #12;
    @(negedge clk);
    chk("rst ready1", ready1, 0);
    chk("rst busy1", busy1, 1);
    chk("rst busy2", busy2, 1);
    chk("rst rvalid1", rvalid1, 0);
    chk("rst rvalid2", rvalid2, 0);
    chk("rst rdata1", rdata1, 0);
    chk("rst rdata2", rdata2, 0);
    rst_n = 1'b1;
    wait_clear("init clear", 8, -1);

    foreach (vecs[i]) do_vec(vecs[i]);

    // back-to-back reads of 1,2,3
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 6'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      v1[k] = rvalid1; d1[k] = rdata1; v2[k] = rvalid2; d2[k] = rdata2;
      if (k == 0) addr = 6'd2;
      else if (k == 1) addr = 6'd3;
      else req = 1'b0;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("b2b rvalid1[%0d]", k), v1[k], k < 3);
      chk($sformatf("b2b rvalid2[%0d]", k), v2[k], (k >= 1) && (k <= 3));
      if (k < 3) chk($sformatf("b2b rdata1[%0d]", k), d1[k], expd[k]);
      if (k >= 1 && k <= 3) chk($sformatf("b2b rdata2[%0d]", k), d2[k], expd[k-1]);
    end

    // read-after-write next cycle
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 6'd9; wdata = 16'hBEEF; be = 2'b11;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    req = 1'b0;
    chk("raw rvalid1", rvalid1, 1);
    chk("raw rdata1", rdata1, 16'hBEEF);
    @(negedge clk);
    chk("raw rvalid2", rvalid2, 1);
    chk("raw rdata2", rdata2, 16'hBEEF);

    // read in flight when clr is accepted keeps pre-clear data
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 6'd3;
    @(negedge clk);
    req = 1'b0; clr = 1'b1;
    chk("inflight rvalid1", rvalid1, 1);
    chk("inflight rdata1", rdata1, 16'h0033);
    @(negedge clk);
    clr = 1'b0;
    chk("inflight rvalid2", rvalid2, 1);
    chk("inflight rdata2", rdata2, 16'h0033);
    wait_clear("clr seq", 8, -1);
    add(0, 6'd3, 16'h0, 2'b00, 16'h0000);
    add(1, 6'd2, 16'h0077, 2'b11, 16'h0);
    add(0, 6'd2, 16'h0, 2'b00, 16'h0077);
    do_vec(vecs[16]);
    do_vec(vecs[17]);
    do_vec(vecs[18]);

    // clr and write request together: clr wins, extra clr pulses ignored
    @(negedge clk);
    clr = 1'b1; req = 1'b1; we = 1'b1; addr = 6'd2; wdata = 16'h1234; be = 2'b11;
    #1;
    chk("clr+req ready1", ready1, 0);
    chk("clr+req ready2", ready2, 0);
    @(negedge clk);
    clr = 1'b0; req = 1'b0; we = 1'b0;
    chk("clr+req busy1", busy1, 1);
    wait_clear("clr+req seq", 8, 3);
    add(0, 6'd2, 16'h0, 2'b00, 16'h0000);
    add(0, 6'd8, 16'h0, 2'b00, 16'h5A5A);
    add(0, 6'd9, 16'h0, 2'b00, 16'hBEEF);
    do_vec(vecs[19]);
    do_vec(vecs[20]);
    do_vec(vecs[21]);

    // reset with a read in flight, then reset again mid-clear
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 6'd9;
    @(negedge clk);
    req = 1'b0;
    chk("pre-rst rvalid1", rvalid1, 1);
    rst_n = 1'b0;
    #1;
    chk("rst rd rvalid1", rvalid1, 0);
    chk("rst rd rvalid2", rvalid2, 0);
    chk("rst rd rdata1", rdata1, 0);
    chk("rst rd rdata2", rdata2, 0);
    chk("rst rd busy1", busy1, 1);
    @(negedge clk);
    chk("rst rd rvalid2 held", rvalid2, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid-clear busy1", busy1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid-clear rst busy1", busy1, 1);
    chk("mid-clear rst ready1", ready1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("restart clear", 8, -1);
    do_vec(vecs[21]);
    do_vec(vecs[20]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
